// File: rtl/q_6_24_pkg.sv
// Shared types, legal code table and successor function for the sequence monitor.
package q_6_24_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACQ   = 2'b01,
    ST_LOCK  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    EC_NONE    = 2'b00,
    EC_ILLEGAL = 2'b01,
    EC_SKIP    = 2'b10,
    EC_STALL   = 2'b11
  } err_code_t;

  localparam int NUM_PH = 6;

  localparam logic [2:0] C0 = 3'b000;
  localparam logic [2:0] C1 = 3'b001;
  localparam logic [2:0] C2 = 3'b011;
  localparam logic [2:0] C3 = 3'b111;
  localparam logic [2:0] C4 = 3'b110;
  localparam logic [2:0] C5 = 3'b100;

  // Index i holds the code decoded onto phase bit i.
  localparam logic [NUM_PH-1:0][2:0] LEGAL_CODES = {C5, C4, C3, C2, C1, C0};

  // Successor in the six-state ring; illegal codes map to 000 (never used
  // for checking because an illegal sample faults first).
  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      C0:      next_code = C1;
      C1:      next_code = C2;
      C2:      next_code = C3;
      C3:      next_code = C4;
      C4:      next_code = C5;
      C5:      next_code = C0;
      default: next_code = C0;
    endcase
  endfunction

endpackage

// File: rtl/q_6_24_seq_monitor_if.sv
// Bus between the sequence counter side and the monitor.
interface q_6_24_seq_monitor_if #(parameter int CYC_W = 8);
  logic [2:0]       count;
  logic [5:0]       phase;
  logic             in_seq;
  logic             cyc_done;
  logic [CYC_W-1:0] cycles;
  logic             err;
  logic [1:0]       err_code;

  modport master (output count, input phase, in_seq, cyc_done, cycles, err, err_code);
  modport slave  (input count, output phase, in_seq, cyc_done, cycles, err, err_code);
endinterface

// File: rtl/q_6_24_seq_decode.sv
// Combinational decode of one 3-bit code: legality, one-hot phase, successor.
module q_6_24_seq_decode
  import q_6_24_pkg::*;
(
  input  logic [2:0]        code,
  output logic              legal,
  output logic [NUM_PH-1:0] onehot,
  output logic [2:0]        succ
);

  // One comparator per legal code; codes are distinct so at most one bit fires.
  for (genvar i = 0; i < NUM_PH; i++) begin : g_ph
    assign onehot[i] = (code == LEGAL_CODES[i]);
  end

  assign legal = |onehot;
  assign succ  = next_code(code);

endmodule

// File: rtl/q_6_24_seq_monitor.sv
// Checker for the six-state sequence counter: lock FSM, phase decode,
// round counter and sticky first-fault capture.
module q_6_24_seq_monitor
  import q_6_24_pkg::*;
#(
  parameter int CYC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  q_6_24_seq_monitor_if.slave  bus
);

  state_t            state, state_n;
  err_code_t         fault_n, err_code_q;
  logic [2:0]        prev, prev_succ;
  logic              legal;
  logic [NUM_PH-1:0] onehot, phase_n, phase_q;
  logic [2:0]        succ;
  logic              round_n, cyc_done_q;
  logic [CYC_W-1:0]  cycles_q;
  logic              is_succ, is_zero, is_hold;

  q_6_24_seq_decode u_dec (
    .code   (bus.count),
    .legal  (legal),
    .onehot (onehot),
    .succ   (succ)
  );

  // prev_succ is the successor of prev, registered alongside it so the
  // comparison is a plain equality against the current sample.
  assign is_succ = (bus.count == prev_succ);
  assign is_zero = (bus.count == C0);
  assign is_hold = (bus.count == prev);

  // State register; reset wins over every transition, FAULT included.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state and fault classification (ILLEGAL > STALL > SKIP).
  always_comb begin
    state_n = state;
    fault_n = EC_NONE;
    case (state)
      ST_IDLE: begin
        if (legal) state_n = ST_ACQ;
        else begin
          state_n = ST_FAULT;
          fault_n = EC_ILLEGAL;
        end
      end
      ST_ACQ, ST_LOCK: begin
        if (!legal) begin
          state_n = ST_FAULT;
          fault_n = EC_ILLEGAL;
        end else if (is_succ) begin
          state_n = ST_LOCK;
        end else if (is_zero) begin
          // Upstream held in or re-entering reset: re-acquire quietly.
          state_n = ST_ACQ;
        end else if (is_hold) begin
          state_n = ST_FAULT;
          fault_n = EC_STALL;
        end else begin
          state_n = ST_FAULT;
          fault_n = EC_SKIP;
        end
      end
      default: state_n = ST_FAULT;
    endcase
  end

  // Output decode: phase of the current sample and the round-complete strobe.
  always_comb begin
    phase_n = '0;
    if (state_n == ST_ACQ || state_n == ST_LOCK) phase_n = onehot;
    round_n = (state == ST_LOCK) && (state_n == ST_LOCK) && (prev == C5);
  end

  // Datapath registers: sample history, phase, round counter, first fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= C0;
      prev_succ  <= C1;
      phase_q    <= '0;
      cyc_done_q <= 1'b0;
      cycles_q   <= '0;
      err_code_q <= EC_NONE;
    end else begin
      prev       <= bus.count;
      prev_succ  <= succ;
      phase_q    <= phase_n;
      cyc_done_q <= round_n;
      if (round_n) cycles_q <= cycles_q + 1'b1;
      if (state != ST_FAULT && state_n == ST_FAULT) err_code_q <= fault_n;
    end
  end

  assign bus.phase    = phase_q;
  assign bus.in_seq   = (state == ST_LOCK);
  assign bus.cyc_done = cyc_done_q;
  assign bus.cycles   = cycles_q;
  assign bus.err      = (state == ST_FAULT);
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_q_6_24_seq_monitor.sv
// Directed bench: two monitors (CYC_W=8 and CYC_W=2) watch the same stream.
module tb_q_6_24_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cnt = 3'b000;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  q_6_24_seq_monitor_if #(.CYC_W(8)) b8 ();
  q_6_24_seq_monitor_if #(.CYC_W(2)) b2 ();
  assign b8.count = cnt;
  assign b2.count = cnt;

  q_6_24_seq_monitor #(.CYC_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  q_6_24_seq_monitor #(.CYC_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  // Round order and expected one-hot phase per sample.
  logic [2:0] rnd [6] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
  logic [5:0] ph  [6] = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
  logic [1:0] cw2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] c);
    cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cnt = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".phase"},    32'(b8.phase),    32'h0);
    chk({tag, ".in_seq"},   32'(b8.in_seq),   32'h0);
    chk({tag, ".cyc_done"}, 32'(b8.cyc_done), 32'h0);
    chk({tag, ".cycles"},   32'(b8.cycles),   32'h0);
    chk({tag, ".err"},      32'(b8.err),      32'h0);
    chk({tag, ".err_code"}, 32'(b8.err_code), 32'h0);
  endtask

  task automatic one_round();
    for (int i = 0; i < 6; i++) step(rnd[i]);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_reset("rst0");
    chk("rst0.cycles2", 32'(b2.cycles), 32'h0);

    // Acquire on 000 holds, then two full rounds
    step(3'b000);
    chk("acq.phase", 32'(b8.phase), 32'h01);
    chk("acq.in_seq", 32'(b8.in_seq), 32'h0);
    step(3'b000);
    step(3'b000);
    chk("acq_hold.phase", 32'(b8.phase), 32'h01);
    chk("acq_hold.err", 32'(b8.err), 32'h0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        step(rnd[i]);
        chk("run.phase", 32'(b8.phase), 32'(ph[i]));
        chk("run.in_seq", 32'(b8.in_seq), 32'h1);
        chk("run.cyc_done", 32'(b8.cyc_done), (i == 5) ? 32'h1 : 32'h0);
        chk("run.cycles", 32'(b8.cycles), 32'(r + ((i == 5) ? 1 : 0)));
      end
    end
    chk("run.err", 32'(b8.err), 32'h0);

    // ILLEGAL while locked, sticky through legal samples
    step(3'b001);
    step(3'b010);
    chk("ill.err", 32'(b8.err), 32'h1);
    chk("ill.code", 32'(b8.err_code), 32'h1);
    chk("ill.phase", 32'(b8.phase), 32'h0);
    chk("ill.in_seq", 32'(b8.in_seq), 32'h0);
    for (int i = 0; i < 10; i++) step(rnd[i % 6]);
    chk("ill_hold.err", 32'(b8.err), 32'h1);
    chk("ill_hold.code", 32'(b8.err_code), 32'h1);
    chk("ill_hold.phase", 32'(b8.phase), 32'h0);
    chk("ill_hold.cycles", 32'(b8.cycles), 32'h2);
    chk("ill_hold.cyc_done", 32'(b8.cyc_done), 32'h0);
    do_reset();
    chk_reset("rst1");

    // SKIP: 001 then 111 after one completed round
    step(3'b000);
    one_round();
    chk("skip.pre_cycles", 32'(b8.cycles), 32'h1);
    step(3'b001);
    step(3'b111);
    chk("skip.err", 32'(b8.err), 32'h1);
    chk("skip.code", 32'(b8.err_code), 32'h2);
    chk("skip.in_seq", 32'(b8.in_seq), 32'h0);
    step(3'b110);
    step(3'b100);
    step(3'b000);
    chk("skip.cycles", 32'(b8.cycles), 32'h1);
    chk("skip.cyc_done", 32'(b8.cyc_done), 32'h0);
    do_reset();
    chk_reset("rst2");

    // STALL: hold 011 for two samples
    step(3'b000);
    step(3'b001);
    step(3'b011);
    chk("stall.first_err", 32'(b8.err), 32'h0);
    chk("stall.first_in_seq", 32'(b8.in_seq), 32'h1);
    step(3'b011);
    chk("stall.err", 32'(b8.err), 32'h1);
    chk("stall.code", 32'(b8.err_code), 32'h3);
    do_reset();
    chk_reset("rst3");

    // Upstream reset while locked: 111 then 000 re-acquires
    step(3'b000);
    one_round();
    step(3'b001);
    step(3'b011);
    step(3'b111);
    step(3'b000);
    chk("ureset.in_seq", 32'(b8.in_seq), 32'h0);
    chk("ureset.err", 32'(b8.err), 32'h0);
    chk("ureset.cycles", 32'(b8.cycles), 32'h1);
    chk("ureset.cyc_done", 32'(b8.cyc_done), 32'h0);
    chk("ureset.phase", 32'(b8.phase), 32'h01);
    step(3'b001);
    chk("ureset.relock", 32'(b8.in_seq), 32'h1);
    do_reset();
    chk_reset("rst4");

    // Narrow counter wraps modulo 4
    step(3'b000);
    for (int r = 0; r < 5; r++) begin
      one_round();
      chk("wrap.cycles2", 32'(b2.cycles), 32'(cw2[r]));
      chk("wrap.done2", 32'(b2.cyc_done), 32'h1);
      chk("wrap.err2", 32'(b2.err), 32'h0);
    end
    chk("wrap.cycles8", 32'(b8.cycles), 32'h5);

    // Reset mid-round clears everything at that edge
    step(3'b001);
    step(3'b011);
    rst = 1'b1;
    cnt = 3'b111;
    @(posedge clk);
    #1;
    chk_reset("rst_mid");
    chk("rst_mid.cycles2", 32'(b2.cycles), 32'h0);
    chk("rst_mid.in_seq2", 32'(b2.in_seq), 32'h0);
    rst = 1'b0;
    step(3'b111);
    chk("rst_mid.reacq", 32'(b8.phase), 32'h08);
    chk("rst_mid.reacq_in_seq", 32'(b8.in_seq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
